// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered mos6502 ALU with N/V/Z/C flags and a done pulse.
//               Define ALU_DECIMAL_EN to add the BCD adjust (DADJ) state.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out,
  output logic             n_out,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] F_INC = 4'd1, F_DEC = 4'd2, F_ADD = 4'd3, F_SUB = 4'd4,
                         F_AND = 4'd5, F_OR  = 4'd6, F_EOR = 4'd7, F_ASL = 4'd8,
                         F_LSR = 4'd9, F_ROL = 4'd10, F_ROR = 4'd11, F_CMP = 4'd12;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DADJ = 1'b1} state_t;
  state_t r_state;

  logic [WIDTH-1:0] w_bop;
  logic             w_cin;
  logic [WIDTH:0]   w_add;
  logic             w_v;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_flag_src;
  logic             w_c;
  logic             w_vupd;

  // INC, DEC, ADD, SUB and CMP share one WIDTH+1 bit adder.
  always_comb begin
    w_bop = b_in;
    w_cin = c_in;
    case (func)
      F_INC:   begin w_bop = '0;    w_cin = 1'b1; end
      F_DEC:   begin w_bop = '1;    w_cin = 1'b0; end
      F_SUB:   w_bop = ~b_in;
      F_CMP:   begin w_bop = ~b_in; w_cin = 1'b1; end
      default: ;
    endcase
  end

  assign w_add = {1'b0, a_in} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
  assign w_v   = (a_in[WIDTH-1] == w_bop[WIDTH-1]) && (w_add[WIDTH-1] != a_in[WIDTH-1]);

  always_comb begin
    w_res      = a_in;
    w_c        = c_in;
    w_vupd     = 1'b0;
    w_flag_src = '0;
    case (func)
      F_INC, F_DEC: w_res = w_add[WIDTH-1:0];
      F_ADD, F_SUB: begin
        w_res  = w_add[WIDTH-1:0];
        w_c    = w_add[WIDTH];
        w_vupd = 1'b1;
      end
      F_AND: w_res = a_in & b_in;
      F_OR:  w_res = a_in | b_in;
      F_EOR: w_res = a_in ^ b_in;
      F_ASL: begin w_res = {a_in[WIDTH-2:0], 1'b0}; w_c = a_in[WIDTH-1]; end
      F_LSR: begin w_res = {1'b0, a_in[WIDTH-1:1]}; w_c = a_in[0];       end
      F_ROL: begin w_res = {a_in[WIDTH-2:0], c_in}; w_c = a_in[WIDTH-1]; end
      F_ROR: begin w_res = {c_in, a_in[WIDTH-1:1]}; w_c = a_in[0];       end
      F_CMP: w_c = w_add[WIDTH];
      default: ;
    endcase
    w_flag_src = (func == F_CMP) ? w_add[WIDTH-1:0] : w_res;
  end

`ifdef ALU_DECIMAL_EN
  localparam int NNIB = WIDTH / 4;

  logic             w_dec_op;
  logic [4:0]       w_nsum [NNIB];
  logic [NNIB:0]    w_nc;
  logic [WIDTH-1:0] w_int;
  logic [WIDTH-1:0] r_int;
  logic [NNIB-1:0]  r_ncy;
  logic             r_sub;
  logic             r_v;
  logic [WIDTH-1:0] w_dres;
  logic             w_dc;
  logic             w_dcy;
  logic             w_fix;
  logic [4:0]       w_t;
  logic [4:0]       w_u;

  assign w_dec_op = dec && ((func == F_ADD) || (func == F_SUB));
  assign w_nc[0]  = w_cin;

  // Nibble-wise ripple of the same sum, exposing each nibble's carry out.
  for (genvar g = 0; g < NNIB; g++) begin : g_nib
    assign w_nsum[g] = {1'b0, a_in[4*g +: 4]} + {1'b0, w_bop[4*g +: 4]} + {4'd0, w_nc[g]};
    assign w_nc[g+1] = w_nsum[g][4];
    assign w_int[4*g +: 4] = w_nsum[g][3:0];
  end

  // Add correction ripples its own carry upward; subtract borrows are already
  // propagated by the binary pass, so each borrowing nibble just loses 6.
  always_comb begin
    w_dres = r_int;
    w_dcy  = 1'b0;
    w_fix  = 1'b0;
    w_t    = '0;
    w_u    = '0;
    for (int i = 0; i < NNIB; i++) begin
      if (r_sub) begin
        w_t   = {1'b0, r_int[4*i +: 4]};
        w_fix = ~r_ncy[i];
        w_u   = w_t + (w_fix ? 5'd10 : 5'd0);
      end else begin
        w_t   = {1'b0, r_int[4*i +: 4]} + {4'd0, w_dcy};
        w_fix = (w_t > 5'd9) || r_ncy[i];
        w_u   = w_t + (w_fix ? 5'd6 : 5'd0);
        w_dcy = w_u[4] | w_t[4];
      end
      w_dres[4*i +: 4] = w_u[3:0];
    end
    w_dc = r_sub ? r_ncy[NNIB-1] : (w_dcy | r_ncy[NNIB-1]);
  end
`else
  logic w_unused_dec;
  assign w_unused_dec = dec;
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      out     <= '0;
      c_out   <= 1'b0;
      v_out   <= 1'b0;
      z_out   <= 1'b0;
      n_out   <= 1'b0;
      done    <= 1'b0;
`ifdef ALU_DECIMAL_EN
      busy    <= 1'b0;
      r_int   <= '0;
      r_ncy   <= '0;
      r_sub   <= 1'b0;
      r_v     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef ALU_DECIMAL_EN
            if (w_dec_op) begin
              r_int   <= w_int;
              r_ncy   <= w_nc[NNIB:1];
              r_sub   <= (func == F_SUB);
              r_v     <= w_v;
              busy    <= 1'b1;
              r_state <= S_DADJ;
            end else
`endif
            begin
              out   <= w_res;
              c_out <= w_c;
              if (w_vupd) v_out <= w_v;
              z_out <= (w_flag_src == '0);
              n_out <= w_flag_src[WIDTH-1];
              done  <= 1'b1;
            end
          end
        end
`ifdef ALU_DECIMAL_EN
        S_DADJ: begin
          out     <= w_dres;
          c_out   <= w_dc;
          v_out   <= r_v;
          z_out   <= (w_dres == '0);
          n_out   <= w_dres[WIDTH-1];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH 8 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  func;
  logic [7:0]  a, b;
  logic        c_in, dec;
  logic [7:0]  out;
  logic        c_out, v_out, z_out, n_out, busy, done;

  logic        start16;
  logic [3:0]  func16;
  logic [15:0] a16, b16;
  logic        c16, dec16;
  logic [15:0] out16;
  logic        c_out16, v_out16, z_out16, n_out16, busy16, done16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .a_in(a), .b_in(b),
    .c_in(c_in), .dec(dec), .out(out), .c_out(c_out), .v_out(v_out),
    .z_out(z_out), .n_out(n_out), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .func(func16), .a_in(a16), .b_in(b16),
    .c_in(c16), .dec(dec16), .out(out16), .c_out(c_out16), .v_out(v_out16),
    .z_out(z_out16), .n_out(n_out16), .busy(busy16), .done(done16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op; returns one cycle later, in the cycle a binary op signals done.
  task automatic go(input logic [3:0] f, input logic [7:0] va, input logic [7:0] vb,
                    input logic vc);
    start = 1'b1; func = f; a = va; b = vb; c_in = vc;
    step();
  endtask

  // Expected flags packed as {C,V,Z,N}.
  task automatic chk_op(input string tag, input logic [7:0] eo, input logic [3:0] ef);
    chk({tag, " done"}, {15'd0, done}, 16'd1);
    chk({tag, " out"}, {8'd0, out}, {8'd0, eo});
    chk({tag, " cvzn"}, {12'd0, c_out, v_out, z_out, n_out}, {12'd0, ef});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; func = 4'd0; a = 8'd0; b = 8'd0; c_in = 1'b0; dec = 1'b0;
    start16 = 1'b0; func16 = 4'd3; a16 = 16'd0; b16 = 16'd0; c16 = 1'b0; dec16 = 1'b0;
    step();
    step();
    chk("reset out", {8'd0, out}, 16'd0);
    chk("reset cvzn", {12'd0, c_out, v_out, z_out, n_out}, 16'd0);
    chk("reset done", {15'd0, done}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset out16", out16, 16'd0);
    rst = 1'b0;
    step();

    go(4'd3, 8'h7F, 8'h01, 1'b0);  chk_op("add_ovf", 8'h80, 4'b0101);
    go(4'd1, 8'hFF, 8'h00, 1'b1);  chk_op("inc_wrap_vhold", 8'h00, 4'b1110);
    start = 1'b0;
    step();
    chk("idle no done", {15'd0, done}, 16'd0);
    chk("idle hold out", {8'd0, out}, 16'd0);

    go(4'd4, 8'h00, 8'h01, 1'b1);  chk_op("sub_borrow", 8'hFF, 4'b0001);
    go(4'd12, 8'h10, 8'h10, 1'b0); chk_op("cmp_eq", 8'h10, 4'b1010);
    go(4'd12, 8'h05, 8'h06, 1'b0); chk_op("cmp_lt", 8'h05, 4'b0001);
    go(4'd11, 8'h01, 8'h00, 1'b1); chk_op("ror", 8'h80, 4'b1001);
    go(4'd8, 8'h80, 8'h00, 1'b0);  chk_op("asl_b2b", 8'h00, 4'b1010);
    go(4'd9, 8'h03, 8'h00, 1'b0);  chk_op("lsr", 8'h01, 4'b1000);
    go(4'd10, 8'h41, 8'h00, 1'b1); chk_op("rol", 8'h83, 4'b0001);
    go(4'd7, 8'hF0, 8'hFF, 1'b0);  chk_op("eor", 8'h0F, 4'b0000);
    go(4'd5, 8'hF0, 8'h3C, 1'b1);  chk_op("and", 8'h30, 4'b1000);
    go(4'd6, 8'h01, 8'h80, 1'b0);  chk_op("or", 8'h81, 4'b0001);
    go(4'd2, 8'h00, 8'h00, 1'b1);  chk_op("dec_wrap", 8'hFF, 4'b1001);
    go(4'd14, 8'h55, 8'hAA, 1'b0); chk_op("reserved_nop", 8'h55, 4'b0000);
    go(4'd3, 8'h40, 8'h40, 1'b0);  chk_op("add_ovf2", 8'h80, 4'b0101);
    go(4'd5, 8'hFF, 8'h0F, 1'b0);  chk_op("and_vhold", 8'h0F, 4'b0100);
    start = 1'b0;
    step();

`ifdef ALU_DECIMAL_EN
    dec = 1'b1;
    go(4'd3, 8'h49, 8'h01, 1'b0);
    chk("dadd busy c1", {15'd0, busy}, 16'd1);
    chk("dadd no done c1", {15'd0, done}, 16'd0);
    dec = 1'b0; func = 4'd1; a = 8'h00;
    step();
    chk_op("dadd", 8'h50, 4'b0000);
    chk("dadd busy c2", {15'd0, busy}, 16'd0);
    start = 1'b0;
    step();
    chk("dadd no extra done", {15'd0, done}, 16'd0);
    chk("dadd hold", {8'd0, out}, 16'h0050);

    dec = 1'b1;
    go(4'd4, 8'h00, 8'h01, 1'b1);
    start = 1'b0;
    step();
    chk_op("dsub_wrap", 8'h99, 4'b0001);
    step();

    go(4'd4, 8'h50, 8'h01, 1'b1);
    chk("dsub busy", {15'd0, busy}, 16'd1);
    start = 1'b0; rst = 1'b1;
    step();
    chk("rst_mid out", {8'd0, out}, 16'd0);
    chk("rst_mid cvzn", {12'd0, c_out, v_out, z_out, n_out}, 16'd0);
    chk("rst_mid done", {15'd0, done}, 16'd0);
    chk("rst_mid busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    step();
    chk("rst_mid no late done", {15'd0, done}, 16'd0);
    dec = 1'b0;
    go(4'd3, 8'h01, 8'h01, 1'b0);  chk_op("after_rst add", 8'h02, 4'b0000);
    start = 1'b0;
    step();
`else
    dec = 1'b1;
    go(4'd3, 8'h49, 8'h01, 1'b0);  chk_op("dec_ignored add", 8'h4A, 4'b0000);
    chk("dec_ignored busy", {15'd0, busy}, 16'd0);
    dec = 1'b0; start = 1'b0;
    step();
`endif

    start16 = 1'b1; func16 = 4'd3; a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
    step();
    start16 = 1'b0;
    chk("w16 done", {15'd0, done16}, 16'd1);
    chk("w16 out", out16, 16'h0000);
    chk("w16 cvzn", {12'd0, c_out16, v_out16, z_out16, n_out16}, 16'b1010);
    step();
    chk("w16 done drops", {15'd0, done16}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
